// File: rtl/jtag_tdo_mux_n.sv
// jtag_tdo_mux_n
//   JTAG TDO output multiplexer for the DCD/DHP TAP, generalised to N_CHAN
//   data-register chains. It sits between the TAP controller / IR block and
//   the TDO pad. The block provides:
//     - a parameterised opcode table (CHAN_OPCODES)
//     - a built-in 1-bit bypass register
//     - falling-edge registered TDO and output enable
//     - exported one-hot chain selects
//     - a sticky illegal-opcode flag
//
// Optional feature (compile-time macro JTAG_SCAN_LEN_CNT_EN):
//   When the macro is defined, the block counts DR shift cycles and exports
//   the length of the last completed DR scan on scan_len_o.
//
// Ports:
//   tck                     JTAG clock; the only clock
//   trst_n                  synchronous active-low reset
//   tdi                     serial data in (feeds the bypass register)
//   state_shift_ir          TAP state decode
//   state_shift_dr          TAP state decode
//   state_pause_dr          TAP state decode
//   state_test_logic_reset  TAP state decode; clears bad_opcode_o
//   instruction_tdo         IR serial out
//   chain_tdo_i[N_CHAN]     serial out of each DR chain
//   latched_jtag_ir         current instruction
//   tdo_pad_o               TDO pad data (updated on negedge tck)
//   tdo_padoe_o             TDO pad output enable (updated on negedge tck)
//   chain_sel_o[N_CHAN]     one-hot registered chain select
//   bypass_sel_o            bypass register selected
//   bad_opcode_o            sticky: an unmapped opcode has been seen
//   scan_len_o              length of the last DR scan (macro builds only)

module jtag_tdo_mux_n #(
  parameter int unsigned IR_LENGTH      = 4,
  parameter int unsigned N_CHAN         = 4,
  parameter logic [N_CHAN*IR_LENGTH-1:0] CHAN_OPCODES = {4'h8, 4'h4, 4'h2, 4'h1},
  parameter logic [IR_LENGTH-1:0] BYPASS_OPCODE       = '1,
  parameter int unsigned SCAN_CNT_WIDTH = 16
) (
  input  logic                      tck,
  input  logic                      trst_n,
  input  logic                      tdi,
  input  logic                      state_shift_ir,
  input  logic                      state_shift_dr,
  input  logic                      state_pause_dr,
  input  logic                      state_test_logic_reset,
  input  logic                      instruction_tdo,
  input  logic [N_CHAN-1:0]         chain_tdo_i,
  input  logic [IR_LENGTH-1:0]      latched_jtag_ir,
  output logic                      tdo_pad_o,
  output logic                      tdo_padoe_o,
  output logic [N_CHAN-1:0]         chain_sel_o,
  output logic                      bypass_sel_o,
  output logic                      bad_opcode_o
`ifdef JTAG_SCAN_LEN_CNT_EN
  ,
  output logic [SCAN_CNT_WIDTH-1:0] scan_len_o
`endif
);

  logic              bypass_reg;
  logic [N_CHAN-1:0] chain_hit;
  logic              any_hit;
  logic              is_bypass;
  logic [N_CHAN-1:0] next_sel;
  logic              next_byp;
  logic              illegal;
  logic              chain_active;
  logic              chain_bit;

  // Bypass register: a 1-bit DR path, shifted on the rising edge.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      bypass_reg <= 1'b0;
    end else if (state_shift_dr) begin
      bypass_reg <= tdi;
    end
  end

  // Opcode decode.
  // The table is scanned from index 0 upward and the first hit wins, so a
  // duplicated opcode always resolves to the lowest index. The BYPASS opcode
  // overrides the table even when it also appears in it.
  always_comb begin
    chain_hit = '0;
    any_hit   = 1'b0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (!any_hit && (latched_jtag_ir == CHAN_OPCODES[i*IR_LENGTH +: IR_LENGTH])) begin
        chain_hit[i] = 1'b1;
        any_hit      = 1'b1;
      end
    end
    is_bypass = (latched_jtag_ir == BYPASS_OPCODE);
    next_sel  = is_bypass ? '0 : chain_hit;
    next_byp  = is_bypass | ~any_hit;
    illegal   = ~is_bypass & ~any_hit;
  end

  // The mux uses the registered selects, so an IR change reaches TDO one
  // negedge after it is decoded.
  assign chain_active = |chain_sel_o;
  assign chain_bit    = |(chain_sel_o & chain_tdo_i);

  always_ff @(negedge tck) begin
    if (!trst_n) begin
      chain_sel_o  <= '0;
      bypass_sel_o <= 1'b0;
      bad_opcode_o <= 1'b0;
      tdo_pad_o    <= 1'b0;
      tdo_padoe_o  <= 1'b0;
    end else begin
      chain_sel_o  <= next_sel;
      bypass_sel_o <= next_byp;
      // When set and clear occur on the same edge, clear wins.
      if (state_test_logic_reset) begin
        bad_opcode_o <= 1'b0;
      end else if (illegal) begin
        bad_opcode_o <= 1'b1;
      end
      tdo_padoe_o <= state_shift_ir | state_shift_dr | state_pause_dr;
      if (state_shift_ir) begin
        tdo_pad_o <= instruction_tdo;
      end else if (chain_active) begin
        tdo_pad_o <= chain_bit;
      end else begin
        tdo_pad_o <= bypass_reg;
      end
    end
  end

`ifdef JTAG_SCAN_LEN_CNT_EN
  logic [SCAN_CNT_WIDTH-1:0] scan_cnt;

  // The counter saturates at all-ones and holds through pause_dr.
  // Its value is published when the scan leaves shift_dr / pause_dr.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      scan_cnt   <= '0;
      scan_len_o <= '0;
    end else if (state_shift_dr) begin
      if (scan_cnt != '1) begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end else if (!state_pause_dr && (scan_cnt != '0)) begin
      scan_len_o <= scan_cnt;
      scan_cnt   <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_tdo_mux_n.sv
module tb_jtag_tdo_mux_n;

  logic       tck = 1'b0;
  logic       trst_n;
  logic       tdi;
  logic       state_shift_ir;
  logic       state_shift_dr;
  logic       state_pause_dr;
  logic       state_test_logic_reset;
  logic       instruction_tdo;
  logic [3:0] chain_tdo_i;
  logic [3:0] latched_jtag_ir;
  logic       tdo_pad_o;
  logic       tdo_padoe_o;
  logic [3:0] chain_sel_o;
  logic       bypass_sel_o;
  logic       bad_opcode_o;
`ifdef JTAG_SCAN_LEN_CNT_EN
  logic [15:0] scan_len_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 tck = ~tck;

  jtag_tdo_mux_n #(
    .IR_LENGTH(4),
    .N_CHAN(4),
    .CHAN_OPCODES({4'h8, 4'h4, 4'h2, 4'h1}),
    .BYPASS_OPCODE(4'hF),
    .SCAN_CNT_WIDTH(16)
  ) dut (
    .tck(tck),
    .trst_n(trst_n),
    .tdi(tdi),
    .state_shift_ir(state_shift_ir),
    .state_shift_dr(state_shift_dr),
    .state_pause_dr(state_pause_dr),
    .state_test_logic_reset(state_test_logic_reset),
    .instruction_tdo(instruction_tdo),
    .chain_tdo_i(chain_tdo_i),
    .latched_jtag_ir(latched_jtag_ir),
    .tdo_pad_o(tdo_pad_o),
    .tdo_padoe_o(tdo_padoe_o),
    .chain_sel_o(chain_sel_o),
    .bypass_sel_o(bypass_sel_o),
    .bad_opcode_o(bad_opcode_o)
`ifdef JTAG_SCAN_LEN_CNT_EN
    ,
    .scan_len_o(scan_len_o)
`endif
  );

  // Inputs change 1 ns after a falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    trst_n                 = 1'b0;
    tdi                    = 1'b0;
    state_shift_ir         = 1'b0;
    state_shift_dr         = 1'b1;
    state_pause_dr         = 1'b0;
    state_test_logic_reset = 1'b0;
    instruction_tdo        = 1'b0;
    chain_tdo_i            = 4'h0;
    latched_jtag_ir        = 4'h0;

    // Reset held for 3 tck with tdi toggling while shifting.
    for (int i = 0; i < 3; i++) begin
      tdi = ~tdi;
      step();
    end
    chk("rst_tdo",   32'(tdo_pad_o),    32'd0);
    chk("rst_oe",    32'(tdo_padoe_o),  32'd0);
    chk("rst_sel",   32'(chain_sel_o),  32'd0);
    chk("rst_byp",   32'(bypass_sel_o), 32'd0);
    chk("rst_bad",   32'(bad_opcode_o), 32'd0);

    // Release; the bypass register must stay 0 without a shift.
    // The chain 2 input is high, but the selects are still the old (empty) ones.
    trst_n          = 1'b1;
    state_shift_dr  = 1'b0;
    tdi             = 1'b1;
    latched_jtag_ir = 4'h4;
    chain_tdo_i     = 4'b0100;
    step();
    chk("sel_ch2",     32'(chain_sel_o),  32'b0100);
    chk("sel_ch2_byp", 32'(bypass_sel_o), 32'd0);
    chk("byp_hold0",   32'(tdo_pad_o),    32'd0);
    chk("oe_idle",     32'(tdo_padoe_o),  32'd0);

    // Chain 2 drives TDO during shift_dr.
    state_shift_dr = 1'b1;
    chain_tdo_i    = 4'b0100;
    step();
    chk("ch2_tdo_1", 32'(tdo_pad_o),   32'd1);
    chk("ch2_oe",    32'(tdo_padoe_o), 32'd1);
    chain_tdo_i = 4'b1011;
    step();
    chk("ch2_tdo_0", 32'(tdo_pad_o), 32'd0);
    chain_tdo_i = 4'b0100;
    step();
    chk("ch2_tdo_1b", 32'(tdo_pad_o), 32'd1);

    // Bypass opcode: on the first edge, TDO still uses the old chain select.
    latched_jtag_ir = 4'hF;
    chain_tdo_i     = 4'h0;
    tdi             = 1'b1;
    step();
    chk("byp_sel",   32'(bypass_sel_o), 32'd1);
    chk("byp_chsel", 32'(chain_sel_o),  32'd0);
    chk("byp_bad",   32'(bad_opcode_o), 32'd0);
    chk("byp_old",   32'(tdo_pad_o),    32'd0);
    tdi = 1'b1; step(); chk("byp_p0", 32'(tdo_pad_o), 32'd1);
    tdi = 1'b1; step(); chk("byp_p1", 32'(tdo_pad_o), 32'd1);
    tdi = 1'b0; step(); chk("byp_p2", 32'(tdo_pad_o), 32'd0);
    tdi = 1'b1; step(); chk("byp_p3", 32'(tdo_pad_o), 32'd1);
    chk("byp_oe", 32'(tdo_padoe_o), 32'd1);

    // Illegal opcode takes the bypass path and sets the sticky flag.
    latched_jtag_ir = 4'h5;
    tdi             = 1'b0;
    step();
    chk("ill_bad",   32'(bad_opcode_o), 32'd1);
    chk("ill_byp",   32'(bypass_sel_o), 32'd1);
    chk("ill_chsel", 32'(chain_sel_o),  32'd0);
    chk("ill_tdo0",  32'(tdo_pad_o),    32'd0);
    tdi = 1'b1;
    step();
    chk("ill_tdo1", 32'(tdo_pad_o), 32'd1);
    latched_jtag_ir = 4'h1;
    step();
    chk("ill_sticky", 32'(bad_opcode_o), 32'd1);
    chk("ch0_sel",    32'(chain_sel_o),  32'b0001);
    state_test_logic_reset = 1'b1;
    step();
    chk("tlr_clear", 32'(bad_opcode_o), 32'd0);
    // Set and clear on the same edge: clear wins.
    latched_jtag_ir = 4'h5;
    step();
    chk("tlr_wins", 32'(bad_opcode_o), 32'd0);
    state_test_logic_reset = 1'b0;
    step();
    chk("ill_reset", 32'(bad_opcode_o), 32'd1);
    latched_jtag_ir        = 4'h1;
    state_test_logic_reset = 1'b1;
    step();
    state_test_logic_reset = 1'b0;
    chk("tlr_clear2", 32'(bad_opcode_o), 32'd0);

    // shift_ir has priority over a selected chain.
    latched_jtag_ir = 4'h2;
    state_shift_dr  = 1'b0;
    step();
    chk("ch1_sel", 32'(chain_sel_o), 32'b0010);
    state_shift_ir  = 1'b1;
    instruction_tdo = 1'b1;
    chain_tdo_i     = 4'h0;
    step();
    chk("ir_tdo1", 32'(tdo_pad_o),   32'd1);
    chk("ir_oe",   32'(tdo_padoe_o), 32'd1);
    instruction_tdo = 1'b0;
    chain_tdo_i     = 4'b0010;
    step();
    chk("ir_prio", 32'(tdo_pad_o), 32'd0);

    // DR shift on chain 1, then pause holds the output value.
    state_shift_ir = 1'b0;
    state_shift_dr = 1'b1;
    step();
    chk("ch1_tdo", 32'(tdo_pad_o), 32'd1);
    state_shift_dr = 1'b0;
    state_pause_dr = 1'b1;
    step();
    chk("pause_oe",  32'(tdo_padoe_o), 32'd1);
    chk("pause_tdo", 32'(tdo_pad_o),   32'd1);
    step();
    chk("pause_tdo2", 32'(tdo_pad_o), 32'd1);

    // Idle: pad tristated, but the mux keeps updating.
    state_pause_dr = 1'b0;
    chain_tdo_i    = 4'h0;
    step();
    chk("idle_oe",  32'(tdo_padoe_o), 32'd0);
    chk("idle_tdo", 32'(tdo_pad_o),   32'd0);

`ifdef JTAG_SCAN_LEN_CNT_EN
    // 5 shift + 2 pause + 3 shift, then exit -> 8.
    state_shift_dr = 1'b1;
    for (int i = 0; i < 5; i++) step();
    state_shift_dr = 1'b0;
    state_pause_dr = 1'b1;
    for (int i = 0; i < 2; i++) step();
    state_pause_dr = 1'b0;
    state_shift_dr = 1'b1;
    for (int i = 0; i < 3; i++) step();
    state_shift_dr = 1'b0;
    step();
    chk("scan_len8", 32'(scan_len_o), 32'd8);
    state_shift_dr = 1'b1;
    step();
    chk("scan_len_hold", 32'(scan_len_o), 32'd8);
    state_shift_dr = 1'b0;
    step();
    chk("scan_len1", 32'(scan_len_o), 32'd1);
    step();
    chk("scan_len1_hold", 32'(scan_len_o), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
